wb_cmd_master: RTL

Wishbone initiator that turns a simple valid/ready command port into single Wishbone classic-pipelined transactions. Each transaction is one read or one write, with stall handling, ack wait and a timeout abort. It drives peripheral responders such as the buttons/LEDs block at 0x03000000/0x03000004 from a local controller (test sequencer, debug UART bridge). It supports one outstanding transaction at a time.

---
 rtl/wb_cmd_master.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
//==============================================================================
//  Module      : wb_cmd_master
//  Description : Wishbone classic-pipelined initiator. Converts a valid/ready
//                command port into single read or write bus transactions,
//                with one transaction outstanding at a time. It handles
//                responder stalls and waits for the ack. A transaction that
//                is never acked is aborted after TIMEOUT_CYCLES bus cycles and
//                reported with rsp_err.
//
//  Ports       :
//      clk         in   1   system clock, rising edge
//      reset       in   1   synchronous active-high reset
//      cmd_valid   in   1   command request
//      cmd_ready   out  1   high in IDLE; command taken on valid && ready
//      cmd_we      in   1   1 = write, 0 = read
//      cmd_addr    in   32  byte address
//      cmd_data    in   32  write data (ignored for reads)
//      rsp_valid   out  1   one-cycle completion pulse
//      rsp_data    out  32  read data (0 for writes and timeouts)
//      rsp_err     out  1   1 = transaction timed out
//      o_wb_cyc    out  1   Wishbone bus cycle
//      o_wb_stb    out  1   Wishbone request strobe
//      o_wb_we     out  1   Wishbone write enable
//      o_wb_addr   out  32  Wishbone address
//      o_wb_data   out  32  Wishbone write data
//      i_wb_ack    in   1   responder completion
//      i_wb_stall  in   1   responder cannot accept the request
//      i_wb_data   in   32  responder read data
//
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,

    // Command / response port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,

    // Wishbone initiator port
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    // The timeout counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned       c_CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a command
        ST_REQ  = 2'd1,   // strobe asserted, waiting for the responder to take it
        ST_WAIT = 2'd2    // request taken, waiting for the ack
    } state_t;

    state_t              state_q,     state_d;
    logic                cyc_q,       cyc_d;
    logic                stb_q,       stb_d;
    logic                we_q,        we_d;
    logic [31:0]         addr_q,      addr_d;
    logic [31:0]         wdata_q,     wdata_d;
    logic [c_CNT_W-1:0]  cnt_q,       cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [31:0]         rsp_data_q,  rsp_data_d;

    logic                w_busy;       // a bus cycle is in progress
    logic                w_req_taken;  // responder takes the strobe this edge
    logic                w_ack_ok;     // ack that actually completes the transaction
    logic                w_last;       // final counted cycle before the abort

    //--------------------------------------------------------------------------
    // Qualifiers
    //--------------------------------------------------------------------------
    // An ack only counts once the request has been taken: in WAIT, or in REQ on
    // the same edge the stall drops (zero-latency responder). An ack that comes
    // while the responder is still stalling is a protocol error and is dropped.
    always_comb begin
        w_busy      = (state_q == ST_REQ) || (state_q == ST_WAIT);
        w_req_taken = (state_q == ST_REQ) && !i_wb_stall;
        w_ack_ok    = i_wb_ack && (w_req_taken || (state_q == ST_WAIT));
        w_last      = (cnt_q == c_CNT_LAST);
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;           // completion is a single-cycle pulse
        rsp_err_d   = rsp_err_q;      // response fields hold until the next pulse
        rsp_data_d  = rsp_data_q;

        if (w_busy) begin
            cnt_d = cnt_q + c_CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_data;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ, ST_WAIT: begin
                // A valid ack on the final counted cycle still wins over the abort.
                if (w_ack_ok) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = we_q ? 32'h0 : i_wb_data;
                    state_d     = ST_IDLE;
                end else if (w_last) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = 32'h0;
                    state_d     = ST_IDLE;
                end else if (w_req_taken) begin
                    // Pipelined mode: drop the strobe but keep the cycle open.
                    stb_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end

            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State and registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    // Ready is decoded from state so a command can be taken in the same cycle
    // that the previous response is presented.
    assign cmd_ready = (state_q == ST_IDLE);

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = we_q;
    assign o_wb_addr = addr_q;
    assign o_wb_data = wdata_q;

endmodule

`default_nettype wire
